// File: rtl/masked_toffoli_pipe_if.sv
// Stream bundle for the masked Toffoli pipeline: input-side and output-side valid/ready
// channels carrying 2-share a/b/c vectors plus the per-item inverse flag.
interface masked_toffoli_pipe_if #(
    parameter int unsigned LANES = 1
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_inv;
    logic [2*LANES-1:0]   a_in;
    logic [2*LANES-1:0]   b_in;
    logic [2*LANES-1:0]   c_in;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_inv;
    logic [2*LANES-1:0]   a_out;
    logic [2*LANES-1:0]   b_out;
    logic [2*LANES-1:0]   c_out;

    // Producer/consumer environment around the block
    modport master (
        output in_valid, in_inv, a_in, b_in, c_in, out_ready,
        input  in_ready, out_valid, out_inv, a_out, b_out, c_out
    );

    // The pipeline itself
    modport slave (
        input  in_valid, in_inv, a_in, b_in, c_in, out_ready,
        output in_ready, out_valid, out_inv, a_out, b_out, c_out
    );
endinterface

// File: rtl/masked_toffoli_pipe.sv
// Pipelined 2-share masked Toffoli network: each gate x_t ^= ~x_(t+1) & x_(t+2) is split into
// two registered half-steps so that no stage ever combines both shares of a control.
module masked_toffoli_pipe #(
    parameter int unsigned LANES     = 1,
    parameter int unsigned NUM_GATES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    masked_toffoli_pipe_if.slave  bus
);
    localparam int unsigned S = 2 * NUM_GATES;

    // One share of the (a,b,c) triple; index 0 = a, 1 = b, 2 = c
    typedef logic [2:0][LANES-1:0] share_t;

    typedef struct packed {
        share_t s1;
        share_t s0;
    } pair_t;

    share_t       sh0_q [S];
    share_t       sh1_q [S];
    logic [S-1:0] valid_q;
    logic [S-1:0] inv_q;

    share_t       feed0 [S];
    share_t       feed1 [S];
    share_t       nxt0  [S];
    share_t       nxt1  [S];
    logic [S-1:0] feed_inv;
    logic         stall;

    // Target variable of the gate served by stage s; inverse mode walks the gates backwards
    function automatic logic [1:0] stage_target(input int unsigned s, input logic inv);
        int unsigned k;
        k = s / 2;
        return inv ? 2'((NUM_GATES - 1 - k) % 3) : 2'(k % 3);
    endfunction

    // One half-step: only a single share of control C (chosen by use_c0) enters the cone
    function automatic pair_t half_step(
        input share_t     x0,
        input share_t     x1,
        input logic [1:0] tgt,
        input logic       use_c0
    );
        pair_t            r;
        logic [1:0]       bi;
        logic [1:0]       ci;
        logic [LANES-1:0] cs;
        bi      = (tgt == 2'd2) ? 2'd0 : tgt + 2'd1;
        ci      = (tgt == 2'd0) ? 2'd2 : tgt - 2'd1;
        cs      = use_c0 ? x0[ci] : x1[ci];
        r.s0    = x0;
        r.s1    = x1;
        r.s0[tgt] = x0[tgt] ^ (cs & ~x0[bi]);
        r.s1[tgt] = x1[tgt] ^ (cs & x1[bi]);
        return r;
    endfunction

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    // Stage inputs and the half-step result each stage will register
    always_comb begin
        feed0[0] = {bus.c_in[LANES-1:0], bus.b_in[LANES-1:0], bus.a_in[LANES-1:0]};
        feed1[0] = {bus.c_in[2*LANES-1:LANES], bus.b_in[2*LANES-1:LANES],
                    bus.a_in[2*LANES-1:LANES]};
        for (int unsigned s = 1; s < S; s++) begin
            feed0[s] = sh0_q[s-1];
            feed1[s] = sh1_q[s-1];
        end
        feed_inv = {inv_q[S-2:0], bus.in_inv};
        for (int unsigned s = 0; s < S; s++) begin
            {nxt1[s], nxt0[s]} = half_step(feed0[s], feed1[s],
                                           stage_target(s, feed_inv[s]), (s % 2) == 1);
        end
    end

    // Whole pipeline advances together unless the output item is being held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            inv_q   <= '0;
            for (int unsigned s = 0; s < S; s++) begin
                sh0_q[s] <= '0;
                sh1_q[s] <= '0;
            end
        end else if (!stall) begin
            valid_q <= {valid_q[S-2:0], bus.in_valid};
            inv_q   <= feed_inv;
            for (int unsigned s = 0; s < S; s++) begin
                sh0_q[s] <= nxt0[s];
                sh1_q[s] <= nxt1[s];
            end
        end
    end

    assign bus.out_valid = valid_q[S-1];
    assign bus.out_inv   = inv_q[S-1];
    assign bus.a_out     = {sh1_q[S-1][0], sh0_q[S-1][0]};
    assign bus.b_out     = {sh1_q[S-1][1], sh0_q[S-1][1]};
    assign bus.c_out     = {sh1_q[S-1][2], sh0_q[S-1][2]};
endmodule

// File: tb/tb_masked_toffoli_pipe.sv
// Directed bench for masked_toffoli_pipe: a 1-lane/1-gate instance and an 8-lane/3-gate instance.
module tb_masked_toffoli_pipe;
    localparam int NG = 3;
    localparam int S  = 2 * NG;

    typedef struct packed {
        logic       inv;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   out_cnt = 0;
    logic capture_en = 1'b0;
    exp_t exp_q [$];
    logic [47:0] cap_q [$];

    masked_toffoli_pipe_if #(.LANES(8)) bus8 ();
    masked_toffoli_pipe_if #(.LANES(1)) bus1 ();

    masked_toffoli_pipe #(.LANES(8), .NUM_GATES(3)) u8 (.clk(clk), .rst(rst), .bus(bus8));
    masked_toffoli_pipe #(.LANES(1), .NUM_GATES(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        assert (got === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] unshare(input logic [15:0] x);
        return x[15:8] ^ x[7:0];
    endfunction

    function automatic logic [15:0] mask(input logic [7:0] x);
        logic [7:0] m;
        m = 8'($urandom);
        return {m, x ^ m};
    endfunction

    // Sequential unshared reference: gates applied one after another
    function automatic exp_t model(input logic [7:0] a, b, c, input logic inv);
        logic [7:0] x [3];
        int t;
        x[0] = a; x[1] = b; x[2] = c;
        for (int k = 0; k < NG; k++) begin
            t = inv ? (NG - 1 - k) % 3 : k % 3;
            x[t] = x[t] ^ (~x[(t + 1) % 3] & x[(t + 2) % 3]);
        end
        return '{inv: inv, a: x[0], b: x[1], c: x[2]};
    endfunction

    // Present one item from posedge+1 and hold it until accepted; returns at posedge+1
    task automatic send(input logic [15:0] a, b, c, input logic inv, input exp_t e);
        int n = 0;
        bus8.in_valid = 1'b1; bus8.in_inv = inv;
        bus8.a_in = a; bus8.b_in = b; bus8.c_in = c;
        @(negedge clk);
        while (!bus8.in_ready && n < 50) begin
            @(posedge clk); #1; @(negedge clk);
            n++;
        end
        check("send_accept", 64'(bus8.in_ready), 64'd1);
        if (bus8.in_ready) exp_q.push_back(e);
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus8.out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic send_rand(input logic inv);
        logic [7:0] a, b, c;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        send(mask(a), mask(b), mask(c), inv, model(a, b, c, inv));
    endtask

    // Scoreboard on every consumed output of the 8-lane instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus8.out_valid && bus8.out_ready) begin
            out_cnt++;
            check("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_a", 64'(unshare(bus8.a_out)), 64'(e.a));
                check("out_b", 64'(unshare(bus8.b_out)), 64'(e.b));
                check("out_c", 64'(unshare(bus8.c_out)), 64'(e.c));
                check("out_inv", 64'(bus8.out_inv), 64'(e.inv));
                if (capture_en) cap_q.push_back({bus8.a_out, bus8.b_out, bus8.c_out});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sa, sb, sc;
        logic [7:0]  oa [200];
        logic [7:0]  ob [200];
        logic [7:0]  oc [200];
        logic [47:0] snap, cv;
        int idx, c0;

        rst = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_inv = 1'b0; bus8.out_ready = 1'b1;
        bus8.a_in = '0; bus8.b_in = '0; bus8.c_in = '0;
        bus1.in_valid = 1'b0; bus1.in_inv = 1'b0; bus1.out_ready = 1'b1;
        bus1.a_in = '0; bus1.b_in = '0; bus1.c_in = '0;
        #2;
        check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
        check("rst_outputs", 64'({bus8.a_out, bus8.b_out, bus8.c_out, bus8.out_inv}), 64'd0);
        check("rst_in_ready", 64'(bus8.in_ready), 64'd1);
        check("rst_u1_out_valid", 64'(bus1.out_valid), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single gate, fixed shares: a=(0,1) b=(1,1) c=(1,0)
        bus1.a_in = 2'b10; bus1.b_in = 2'b11; bus1.c_in = 2'b01; bus1.in_valid = 1'b1;
        @(negedge clk);
        check("t1_in_ready", 64'(bus1.in_ready), 64'd1);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        @(negedge clk);
        check("t1_lat1", 64'(bus1.out_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_lat2", 64'(bus1.out_valid), 64'd1);
        check("t1_a_shares", 64'(bus1.a_out), 64'd0);
        check("t1_b_shares", 64'(bus1.b_out), 64'd3);
        check("t1_c_shares", 64'(bus1.c_out), 64'd1);
        check("t1_out_inv", 64'(bus1.out_inv), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_consumed", 64'(bus1.out_valid), 64'd0);
        @(posedge clk); #1;

        // Hand-computed 3-gate vectors; first one also measures latency
        send({8'h5A, 8'hF0 ^ 8'h5A}, {8'h33, 8'h0F ^ 8'h33}, {8'hC6, 8'h0F ^ 8'hC6}, 1'b0,
             '{inv: 1'b0, a: 8'hF0, b: 8'hFF, c: 8'h00});
        for (int k = 1; k <= S; k++) begin
            @(negedge clk);
            check("lat_fwd", 64'(bus8.out_valid), 64'(k == S));
            if (k < S) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        send({8'hA5, 8'h5A}, {8'h3C, 8'hC3}, {8'h99, 8'h99}, 1'b1,
             '{inv: 1'b1, a: 8'hFF, b: 8'h00, c: 8'h00});
        send({8'h11, 8'h11}, {8'h22, 8'h22}, {8'h0F, 8'hF0}, 1'b0,
             '{inv: 1'b0, a: 8'hFF, b: 8'h00, c: 8'hFF});
        send({8'h6E, 8'h91}, {8'h48, 8'h48}, {8'h7D, 8'h82}, 1'b1,
             '{inv: 1'b1, a: 8'h00, b: 8'h00, c: 8'hFF});
        drain();

        // All 64 share combinations, one per lane, both modes
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 8; i++) begin
                for (int l = 0; l < 8; l++) begin
                    idx = i * 8 + l;
                    sa[l] = idx[0]; sa[8+l] = idx[1];
                    sb[l] = idx[2]; sb[8+l] = idx[3];
                    sc[l] = idx[4]; sc[8+l] = idx[5];
                end
                send(sa, sb, sc, 1'(m),
                     model(unshare(sa), unshare(sb), unshare(sc), 1'(m)));
            end
        end
        drain();

        // 200 back-to-back forward items; out_valid must be continuous after S cycles
        capture_en = 1'b1;
        for (int j = 0; j < 200 + S; j++) begin
            if (j < 200) begin
                oa[j] = 8'($urandom); ob[j] = 8'($urandom); oc[j] = 8'($urandom);
                bus8.a_in = mask(oa[j]); bus8.b_in = mask(ob[j]); bus8.c_in = mask(oc[j]);
                bus8.in_inv = 1'b0; bus8.in_valid = 1'b1;
            end else begin
                bus8.in_valid = 1'b0;
            end
            @(negedge clk);
            check("thru_valid", 64'(bus8.out_valid), 64'(j >= S));
            if (j < 200) exp_q.push_back(model(oa[j], ob[j], oc[j], 1'b0));
            @(posedge clk); #1;
        end
        bus8.in_valid = 1'b0;
        drain();
        capture_en = 1'b0;
        check("capture_count", 64'(cap_q.size()), 64'd200);

        // Feed results back inverted: originals must reappear
        for (int j = 0; j < 200 && cap_q.size() != 0; j++) begin
            cv = cap_q.pop_front();
            send(cv[47:32], cv[31:16], cv[15:0], 1'b1,
                 '{inv: 1'b1, a: oa[j], b: ob[j], c: oc[j]});
        end
        drain();

        // Backpressure: fill, hold 5 cycles with a competing input, then release
        bus8.out_ready = 1'b0;
        c0 = out_cnt;
        for (int i = 0; i < S; i++) send_rand(1'(i % 2));
        bus8.in_valid = 1'b1; bus8.in_inv = 1'b0;
        bus8.a_in = 16'hBEEF; bus8.b_in = 16'h1234; bus8.c_in = 16'h5678;
        @(negedge clk);
        check("stall_out_valid", 64'(bus8.out_valid), 64'd1);
        check("stall_in_ready", 64'(bus8.in_ready), 64'd0);
        snap = {bus8.a_out, bus8.b_out, bus8.c_out};
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("stall_in_ready_hold", 64'(bus8.in_ready), 64'd0);
            check("stall_valid_hold", 64'(bus8.out_valid), 64'd1);
            check("stall_data_hold", 64'({bus8.a_out, bus8.b_out, bus8.c_out}), 64'(snap));
            check("stall_inv_hold", 64'(bus8.out_inv), 64'd0);
        end
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        drain();
        check("stall_item_count", 64'(out_cnt - c0), 64'(S));

        // Asynchronous reset mid-stream, with an input offered while reset is held
        for (int i = 0; i < S + 1; i++) send_rand(1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(bus8.out_valid), 64'd0);
        check("arst_outputs", 64'({bus8.a_out, bus8.b_out, bus8.c_out, bus8.out_inv}), 64'd0);
        check("arst_in_ready", 64'(bus8.in_ready), 64'd1);
        exp_q.delete();
        bus8.in_valid = 1'b1; bus8.in_inv = 1'b0;
        bus8.a_in = 16'h0FF0; bus8.b_in = 16'hF00F; bus8.c_in = 16'h3C3C;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        rst = 1'b0;
        send({8'h11, 8'h11}, {8'h22, 8'h22}, {8'h0F, 8'hF0}, 1'b0,
             '{inv: 1'b0, a: 8'hFF, b: 8'h00, c: 8'hFF});
        for (int k = 1; k <= S; k++) begin
            @(negedge clk);
            check("lat_after_rst", 64'(bus8.out_valid), 64'(k == S));
            if (k < S) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
